// File: rtl/mips_mc_controller_if.sv
// Datapath-facing bundle of the multicycle MIPS controller: opcode/flag/handshake
// inputs and the per-cycle control strobes.
interface mips_mc_controller_if;
   logic [5:0] op;
   logic       zero;
   logic       memready;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       zeroext;
   logic [1:0] pcsrc;
   logic [1:0] aluop;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  op, zero, memready,
      output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, zeroext, pcsrc, aluop, illegal, state
   );

   modport slave (
      output op, zero, memready,
      input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, zeroext, pcsrc, aluop, illegal, state
   );
endinterface

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: decodes the opcode and drives the per-cycle
// datapath strobes, stalling on memready during fetch, load read and store write.
module mips_mc_controller #(
   parameter bit USE_MEMREADY = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_mc_controller_if.master  bus
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      EXECUTE = 4'd6,
      ALUWB   = 4'd7,
      BRANCH  = 4'd8,
      ADDIEX  = 4'd9,
      IMMWB   = 4'd10,
      JUMP    = 4'd11,
      ORIEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   state_t state_q, state_d;
   logic   mr;

   assign mr        = USE_MEMREADY ? bus.memready : 1'b1;
   assign bus.state = state_q;

   // NOTE: state register uses non-blocking assignment so every reader sees the pre-edge value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d      = FETCH;
      bus.pcen     = 1'b0;
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
      bus.iord     = 1'b0;
      bus.memtoreg = 1'b0;
      bus.regdst   = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = 2'b00;
      bus.zeroext  = 1'b0;
      bus.pcsrc    = 2'b00;
      bus.aluop    = 2'b00;
      bus.illegal  = 1'b0;

      case (state_q)
         FETCH: begin
            bus.alusrcb = 2'b01;
            bus.irwrite = mr;
            bus.pcen    = mr;
            state_d     = mr ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alusrcb = 2'b11;
            case (bus.op)
               OP_LW, OP_SW:   state_d = MEMADR;
               OP_R:           state_d = EXECUTE;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_ADDI:        state_d = ADDIEX;
               OP_ORI:         state_d = ORIEX;
               OP_J:           state_d = JUMP;
               default: begin
                  state_d     = FETCH;
                  bus.illegal = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            state_d     = (bus.op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.iord = 1'b1;
            state_d  = mr ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.regwrite = 1'b1;
            bus.memtoreg = 1'b1;
         end
         MEMWR: begin
            // Write strobe stays up for the whole stall so the memory sees a stable request.
            bus.iord     = 1'b1;
            bus.memwrite = 1'b1;
            state_d      = mr ? FETCH : MEMWR;
         end
         EXECUTE: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 2'b10;
            state_d     = ALUWB;
         end
         ALUWB: begin
            bus.regwrite = 1'b1;
            bus.regdst   = 1'b1;
         end
         BRANCH: begin
            bus.alusrca = 1'b1;
            bus.aluop   = 2'b01;
            bus.pcsrc   = 2'b01;
            bus.pcen    = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
         end
         ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            state_d     = IMMWB;
         end
         IMMWB: begin
            bus.regwrite = 1'b1;
         end
         JUMP: begin
            bus.pcsrc = 2'b10;
            bus.pcen  = 1'b1;
         end
         ORIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = 2'b10;
            bus.zeroext = 1'b1;
            bus.aluop   = 2'b11;
            state_d     = IMMWB;
         end
         default: state_d = FETCH;
      endcase
   end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Bench for mips_mc_controller: directed scenarios then random instruction streams,
// each checked cycle by cycle against an instruction-level expected trace.
module tb_mips_mc_controller;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_J    = 6'b000010;

   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic [5:0] op;
      logic       zero;
      logic       pcen, memwrite, irwrite, regwrite, illegal;
      logic       iord, memtoreg, regdst, alusrca, zeroext;
      logic [1:0] alusrcb, pcsrc, aluop;
   } step_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   step_t q[$];

   mips_mc_controller_if bus ();

   mips_mc_controller #(.USE_MEMREADY(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      return op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};
   endfunction

   // Irrelevant inputs are randomised so the trace also proves they are ignored.
   function automatic step_t blank(input logic [3:0] st);
      step_t s;
      s          = '{default: '0};
      s.st       = st;
      s.mr       = 1'($urandom);
      s.op       = 6'($urandom);
      s.zero     = 1'($urandom);
      return s;
   endfunction

   // Expected per-cycle trace of one instruction, built from its class and stalls.
   task automatic build(input logic [5:0] op, input logic zero, input int fs, input int ms);
      step_t s;
      q.delete();
      for (int i = 0; i <= fs; i++) begin
         s = blank(4'd0); s.alusrcb = 2'b01; s.mr = (i == fs);
         s.pcen = s.mr; s.irwrite = s.mr;
         q.push_back(s);
      end
      s = blank(4'd1); s.alusrcb = 2'b11; s.op = op; s.illegal = !is_legal(op);
      q.push_back(s);
      if (op == OP_LW || op == OP_SW) begin
         s = blank(4'd2); s.op = op; s.alusrca = 1'b1; s.alusrcb = 2'b10;
         q.push_back(s);
         for (int i = 0; i <= ms; i++) begin
            s = blank((op == OP_LW) ? 4'd3 : 4'd5); s.iord = 1'b1; s.mr = (i == ms);
            s.memwrite = (op == OP_SW);
            q.push_back(s);
         end
         if (op == OP_LW) begin
            s = blank(4'd4); s.regwrite = 1'b1; s.memtoreg = 1'b1;
            q.push_back(s);
         end
      end else if (op == OP_R) begin
         s = blank(4'd6); s.alusrca = 1'b1; s.aluop = 2'b10; q.push_back(s);
         s = blank(4'd7); s.regwrite = 1'b1; s.regdst = 1'b1; q.push_back(s);
      end else if (op == OP_BEQ || op == OP_BNE) begin
         s = blank(4'd8); s.op = op; s.zero = zero; s.alusrca = 1'b1;
         s.aluop = 2'b01; s.pcsrc = 2'b01;
         s.pcen = (op == OP_BEQ) ? zero : !zero;
         q.push_back(s);
      end else if (op == OP_ADDI || op == OP_ORI) begin
         s = blank((op == OP_ADDI) ? 4'd9 : 4'd12); s.alusrca = 1'b1; s.alusrcb = 2'b10;
         s.zeroext = (op == OP_ORI); s.aluop = (op == OP_ORI) ? 2'b11 : 2'b00;
         q.push_back(s);
         s = blank(4'd10); s.regwrite = 1'b1; q.push_back(s);
      end else if (op == OP_J) begin
         s = blank(4'd11); s.pcsrc = 2'b10; s.pcen = 1'b1; q.push_back(s);
      end
   endtask

   // Called just after a rising edge with the DUT in FETCH.
   task automatic run_instr(input string name, input logic [5:0] op, input logic zero,
                            input int fs, input int ms);
      build(op, zero, fs, ms);
      foreach (q[k]) begin
         bus.op       = q[k].op;
         bus.zero     = q[k].zero;
         bus.memready = q[k].mr;
         #1;
         chk($sformatf("%s[%0d] state", name, k), 16'(bus.state), 16'(q[k].st));
         chk($sformatf("%s[%0d] strobes", name, k),
             16'({bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.illegal}),
             16'({q[k].pcen, q[k].memwrite, q[k].irwrite, q[k].regwrite, q[k].illegal}));
         chk($sformatf("%s[%0d] ctrl", name, k),
             16'({bus.iord, bus.memtoreg, bus.regdst, bus.alusrca, bus.alusrcb,
                  bus.zeroext, bus.pcsrc, bus.aluop}),
             16'({q[k].iord, q[k].memtoreg, q[k].regdst, q[k].alusrca, q[k].alusrcb,
                  q[k].zeroext, q[k].pcsrc, q[k].aluop}));
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] ops [8];
      tests = 0;
      fails = 0;
      ops   = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J};

      // Reset state: FETCH outputs gated by memready.
      reset        = 1'b0;
      bus.op       = OP_R;
      bus.zero     = 1'b0;
      bus.memready = 1'b0;
      #1;
      chk("reset state", 16'(bus.state), 16'd0);
      chk("reset irwrite mr0", 16'({bus.irwrite, bus.pcen}), 16'b00);
      bus.memready = 1'b1;
      #1;
      chk("reset irwrite mr1", 16'({bus.irwrite, bus.pcen, bus.regwrite, bus.memwrite}), 16'b1100);
      bus.memready = 1'b0;
      reset        = 1'b1;

      // Async reset in the middle of EXECUTE.
      bus.memready = 1'b1;
      @(posedge clk); #1;
      chk("pre-reset decode", 16'(bus.state), 16'd1);
      @(posedge clk); #1;
      chk("pre-reset execute", 16'(bus.state), 16'd6);
      reset = 1'b0;
      #1;
      chk("async reset state", 16'(bus.state), 16'd0);
      chk("async reset strobes", 16'({bus.memwrite, bus.regwrite}), 16'b00);
      #1;
      reset = 1'b1;
      run_instr("r_after_reset", OP_R, 1'b0, 0, 0);

      // Directed scenarios.
      run_instr("lw_stall", OP_LW, 1'b0, 2, 3);
      run_instr("sw_stall", OP_SW, 1'b0, 0, 2);
      run_instr("beq_z1", OP_BEQ, 1'b1, 0, 0);
      run_instr("beq_z0", OP_BEQ, 1'b0, 0, 0);
      run_instr("bne_z0", OP_BNE, 1'b0, 0, 0);
      run_instr("bne_z1", OP_BNE, 1'b1, 0, 0);
      run_instr("addi", OP_ADDI, 1'b0, 0, 0);
      run_instr("ori", OP_ORI, 1'b0, 1, 0);
      run_instr("j", OP_J, 1'b0, 0, 0);
      run_instr("illegal", 6'b111111, 1'b0, 0, 0);

      // Async reset while a store is stalled.
      bus.memready = 1'b1; bus.op = OP_SW;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.memready = 1'b0;
      @(posedge clk); #1;
      chk("sw stall memwrite", 16'({bus.state, bus.memwrite}), 16'({4'd5, 1'b1}));
      reset = 1'b0;
      #1;
      chk("sw stall reset", 16'({bus.state, bus.memwrite}), 16'({4'd0, 1'b0}));
      #1;
      reset = 1'b1;

      // Random instruction stream with random stalls.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) < 8) begin
            op = ops[$urandom_range(0, 7)];
         end else begin
            op = 6'($urandom);
            while (is_legal(op)) op = 6'($urandom);
         end
         run_instr($sformatf("rand%0d_op%02h", n, op), op, 1'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
